// File: rtl/cgra_ctrl_pkg.sv
// Shared types for the CGRA array controller.
// Imported by the CSR block, tiles and sequencer.
package cgra_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } seq_state_e;

  localparam int unsigned CfgW = 49;

  typedef logic [CfgW-1:0] cfg_word_t;

  function automatic int unsigned ctx_width(input int unsigned k);
    return (k > 2) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/cgra_tile_accept_tracker.sv
// Per-tile record of which tiles took the current
// broadcast config word.
module cgra_tile_accept_tracker #(
  parameter int unsigned CGRADim = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [CGRADim-1:0] valid,
  input  logic [CGRADim-1:0] ready,
  input  logic               clr,
  output logic [CGRADim-1:0] accepted,
  output logic               all_done
);

  logic [CGRADim-1:0] hs;

  assign hs       = valid & ready;
  assign all_done = &(accepted | hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accepted <= '0;
    end else if (clr) begin
      accepted <= '0;
    end else begin
      accepted <= accepted | hs;
    end
  end

endmodule

// File: rtl/cgra_cfg_exec_sequencer.sv
// Loads every tile's contexts, then steps the array
// through the modulo schedule for N iterations.
module cgra_cfg_exec_sequencer
  import cgra_ctrl_pkg::*;
#(
  parameter int unsigned CGRADim    = 16,
  parameter int unsigned KernelSize = 4,
  parameter int unsigned CfgWidth   = 49,
  parameter int unsigned IterWidth  = 16,
  localparam int unsigned CtxW = ctx_width(KernelSize)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [IterWidth-1:0]              iter_count_i,
  input  logic                              abort_i,
  input  logic                              stall_i,
  output logic [CtxW-1:0]                   cfg_rd_ctx_o,
  input  logic [CGRADim-1:0][CfgWidth-1:0]  cfg_rd_data_i,
  output logic [CtxW-1:0]                   tile_wr_addr_o,
  output logic [CGRADim-1:0][CfgWidth-1:0]  tile_wr_data_o,
  output logic [CGRADim-1:0]                tile_wr_valid_o,
  input  logic [CGRADim-1:0]                tile_ready_i,
  output logic                              exec_en_o,
  output logic [CtxW-1:0]                   exec_ctx_o,
  output logic                              busy_o,
  output logic                              loaded_o,
  output logic                              done_o,
  output logic [IterWidth-1:0]              iter_o
);

  localparam logic [CtxW-1:0] LastCtx = CtxW'(KernelSize - 1);

  seq_state_e         state_q, state_d;
  logic [CtxW-1:0]    ctx_q;
  logic [IterWidth-1:0] iter_q, count_q;
  logic               loaded_q;
  logic [CGRADim-1:0] accepted, valid;
  logic               all_done;
  logic               in_load, in_run, kill;
  logic               last_ctx, last_iter, run_step;

  assign in_load   = (state_q == LOAD);
  assign in_run    = (state_q == RUN);
  assign kill      = abort_i && (state_q != IDLE);
  assign last_ctx  = (ctx_q == LastCtx);
  assign last_iter = (iter_q == count_q - IterWidth'(1));
  assign run_step  = in_run && !stall_i;
  assign valid     = in_load ? ~accepted : '0;

  cgra_tile_accept_tracker #(
    .CGRADim (CGRADim)
  ) u_tracker (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid    (valid),
    .ready    (tile_ready_i),
    .clr      (!in_load || all_done || kill),
    .accepted (accepted),
    .all_done (all_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: begin
        if (all_done && last_ctx)
          state_d = (count_q == '0) ? DONE : RUN;
      end
      RUN:  if (run_step && last_ctx && last_iter) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats completion in the same cycle.
    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_q    <= '0;
      iter_q   <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
    end else if (kill) begin
      ctx_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            count_q  <= iter_count_i;
            ctx_q    <= '0;
            iter_q   <= '0;
            loaded_q <= 1'b0;
          end
        end
        LOAD: begin
          if (all_done) begin
            if (last_ctx) begin
              ctx_q    <= '0;
              loaded_q <= 1'b1;
            end else begin
              ctx_q <= ctx_q + CtxW'(1);
            end
          end
        end
        RUN: begin
          if (!stall_i) begin
            if (last_ctx) begin
              ctx_q  <= '0;
              iter_q <= iter_q + IterWidth'(1);
            end else begin
              ctx_q <= ctx_q + CtxW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_rd_ctx_o    = ctx_q;
    tile_wr_addr_o  = ctx_q;
    tile_wr_data_o  = cfg_rd_data_i;
    tile_wr_valid_o = valid;
    exec_en_o       = run_step;
    exec_ctx_o      = in_run ? ctx_q : '0;
    busy_o          = (state_q != IDLE);
    loaded_o        = loaded_q;
    done_o          = (state_q == DONE);
    iter_o          = iter_q;
  end

endmodule

// File: tb/tb_cgra_cfg_exec_sequencer.sv
// Randomized scenario bench for the CGRA config/exec
// sequencer with a schedule-level reference model.
module tb_cgra_cfg_exec_sequencer;

  localparam int D  = 4;
  localparam int K  = 4;
  localparam int CW = 49;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic stall_i = 1'b0;
  logic [IW-1:0] iter_count_i = '0;
  logic [1:0] cfg_rd_ctx_o, tile_wr_addr_o, exec_ctx_o;
  logic [D-1:0][CW-1:0] cfg_rd_data_i, tile_wr_data_o;
  logic [D-1:0] tile_wr_valid_o;
  logic [D-1:0] tile_ready_i = '0;
  logic exec_en_o, busy_o, loaded_o, done_o;
  logic [IW-1:0] iter_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] mem [K][D];

  always #5 clk = ~clk;

  always_comb begin
    for (int t = 0; t < D; t++)
      cfg_rd_data_i[t] = mem[cfg_rd_ctx_o][t];
  end

  cgra_cfg_exec_sequencer #(
    .CGRADim(D), .KernelSize(K),
    .CfgWidth(CW), .IterWidth(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .start_i(start_i), .iter_count_i(iter_count_i),
    .abort_i(abort_i), .stall_i(stall_i),
    .cfg_rd_ctx_o(cfg_rd_ctx_o),
    .cfg_rd_data_i(cfg_rd_data_i),
    .tile_wr_addr_o(tile_wr_addr_o),
    .tile_wr_data_o(tile_wr_data_o),
    .tile_wr_valid_o(tile_wr_valid_o),
    .tile_ready_i(tile_ready_i),
    .exec_en_o(exec_en_o), .exec_ctx_o(exec_ctx_o),
    .busy_o(busy_o), .loaded_o(loaded_o),
    .done_o(done_o), .iter_o(iter_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int cnt);
    iter_count_i = IW'(cnt);
    start_i = 1'b1;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL start_idle busy=%b exp 0", busy_o);
    end
    tick();
    start_i = 1'b0;
    iter_count_i = IW'($urandom);
  endtask

  // mode 0: all ready, 1: random ready, 2: slow tile at ctx 1
  task automatic do_load(input int mode, input int slow_tile,
                         output int cycles);
    logic [D-1:0] acc, rdy, exp_v;
    logic [D-1:0][CW-1:0] exp_d;
    int slow;
    slow = 0;
    cycles = 0;
    for (int c = 0; c < K; c++) begin
      acc = '0;
      while (acc !== '1) begin
        if (cycles > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL load_timeout ctx=%0d acc=%h", c, acc);
          return;
        end
        rdy = '1;
        if (mode == 1) rdy = D'($urandom);
        if (mode == 2 && c == 1 && slow < 3) begin
          rdy = ~(D'(1) << slow_tile);
          slow++;
        end
        tile_ready_i = rdy;
        #1;
        exp_v = ~acc;
        for (int t = 0; t < D; t++) exp_d[t] = mem[c][t];
        n_cmp++;
        if ({tile_wr_valid_o, tile_wr_addr_o, cfg_rd_ctx_o,
             busy_o, exec_en_o, done_o} !==
            {exp_v, 2'(c), 2'(c), 3'b100}) begin
          n_bad++;
          $display("FAIL load_ctl ctx=%0d got v=%h a=%0d r=%0d b=%b e=%b d=%b exp v=%h a=%0d",
                   c, tile_wr_valid_o, tile_wr_addr_o, cfg_rd_ctx_o,
                   busy_o, exec_en_o, done_o, exp_v, c);
        end
        n_cmp++;
        if (tile_wr_data_o !== exp_d) begin
          n_bad++;
          $display("FAIL load_data ctx=%0d got %h exp %h",
                   c, tile_wr_data_o, exp_d);
        end
        acc = acc | (exp_v & rdy);
        cycles++;
        tick();
      end
    end
    tile_ready_i = '0;
  endtask

  // smode 0: none, 1: 5-cycle stall at step 5, 2: random stall+start
  task automatic do_run(input int cnt, input int smode,
                        input bit abort_last, output int cycles);
    int n, sleft;
    bit st;
    n = 0;
    sleft = 5;
    cycles = 0;
    while (n < cnt * K) begin
      if (cycles > cnt * K + 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL run_timeout n=%0d", n);
        return;
      end
      st = 1'b0;
      if (smode == 1 && n == 5 && sleft > 0) begin
        st = 1'b1;
        sleft--;
      end else if (smode == 2) begin
        st = ($urandom_range(0, 3) == 0);
      end
      stall_i = st;
      start_i = (smode == 2) && ($urandom_range(0, 5) == 0);
      abort_i = abort_last && !st && (n == cnt * K - 1);
      tile_ready_i = D'($urandom);
      #1;
      n_cmp++;
      if ({exec_en_o, exec_ctx_o, iter_o, busy_o, done_o, loaded_o,
           tile_wr_valid_o} !==
          {~st, 2'(n % K), IW'(n / K), 3'b101, 4'h0}) begin
        n_bad++;
        $display("FAIL run step=%0d got en=%b ctx=%0d it=%0d b=%b d=%b l=%b v=%h exp en=%b ctx=%0d it=%0d",
                 n, exec_en_o, exec_ctx_o, iter_o, busy_o, done_o,
                 loaded_o, tile_wr_valid_o, ~st, n % K, n / K);
      end
      if (!st) n++;
      cycles++;
      tick();
    end
    stall_i = 1'b0;
    start_i = 1'b0;
    tile_ready_i = '0;
    if (abort_last) begin
      abort_i = 1'b0;
      #1;
      n_cmp++;
      if ({busy_o, done_o, loaded_o, exec_en_o} !== 4'b0) begin
        n_bad++;
        $display("FAIL abort_final got b=%b d=%b l=%b e=%b exp 0000",
                 busy_o, done_o, loaded_o, exec_en_o);
      end
      return;
    end
    #1;
    n_cmp++;
    if ({done_o, exec_en_o, busy_o, iter_o} !==
        {3'b101, IW'(cnt)}) begin
      n_bad++;
      $display("FAIL done_cycle got d=%b e=%b b=%b it=%0d exp d=1 e=0 b=1 it=%0d",
               done_o, exec_en_o, busy_o, iter_o, cnt);
    end
    tick();
    n_cmp++;
    if ({done_o, busy_o, loaded_o, iter_o} !==
        {3'b001, IW'(cnt)}) begin
      n_bad++;
      $display("FAIL after_done got d=%b b=%b l=%b it=%0d exp d=0 b=0 l=1 it=%0d",
               done_o, busy_o, loaded_o, iter_o, cnt);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_o, done_o, exec_en_o, loaded_o, tile_wr_valid_o,
         iter_o, exec_ctx_o, cfg_rd_ctx_o, tile_wr_addr_o} !== '0) begin
      n_bad++;
      $display("FAIL reset got b=%b d=%b e=%b l=%b v=%h it=%0d exp all 0",
               busy_o, done_o, exec_en_o, loaded_o,
               tile_wr_valid_o, iter_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lc, rc;
    do_start(3);
    do_load(0, 0, lc);
    n_cmp++;
    if (lc !== 4) begin
      n_bad++;
      $display("FAIL basic_load_len got %0d exp 4", lc);
    end
    do_run(3, 0, 1'b0, rc);
    n_cmp++;
    if (rc !== 12) begin
      n_bad++;
      $display("FAIL basic_run_len got %0d exp 12", rc);
    end
  endtask

  task automatic test_slow_tile();
    int lc, rc;
    do_start(1);
    do_load(2, 2, lc);
    n_cmp++;
    if (lc !== 7) begin
      n_bad++;
      $display("FAIL slow_load_len got %0d exp 7", lc);
    end
    do_run(1, 0, 1'b0, rc);
  endtask

  task automatic test_zero_iter();
    int lc, rc;
    do_start(0);
    do_load(1, 0, lc);
    do_run(0, 0, 1'b0, rc);
  endtask

  task automatic test_stall();
    int lc, rc;
    do_start(3);
    do_load(0, 0, lc);
    do_run(3, 1, 1'b0, rc);
    n_cmp++;
    if (rc !== 17) begin
      n_bad++;
      $display("FAIL stall_run_len got %0d exp 17", rc);
    end
  endtask

  task automatic test_abort_load();
    int lc, rc;
    do_start(2);
    tile_ready_i = '1;
    tick();
    tick();
    n_cmp++;
    if ({cfg_rd_ctx_o, tile_wr_valid_o} !== {2'd2, 4'hF}) begin
      n_bad++;
      $display("FAIL abort_pre got ctx=%0d v=%h exp ctx=2 v=f",
               cfg_rd_ctx_o, tile_wr_valid_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({tile_wr_valid_o, busy_o, done_o, loaded_o} !== 7'b0) begin
        n_bad++;
        $display("FAIL abort_load cyc=%0d got v=%h b=%b d=%b l=%b exp 0",
                 i, tile_wr_valid_o, busy_o, done_o, loaded_o);
      end
      tick();
    end
    tile_ready_i = '0;
    do_start(2);
    do_load(0, 0, lc);
    do_run(2, 0, 1'b0, rc);
  endtask

  task automatic test_abort_priority();
    int lc, rc;
    do_start(2);
    do_load(0, 0, lc);
    do_run(2, 0, 1'b1, rc);
    tick();
    n_cmp++;
    if ({done_o, busy_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_prio_late got d=%b b=%b exp 00",
               done_o, busy_o);
    end
  endtask

  task automatic test_start_ignored();
    int lc, rc;
    do_start(4);
    do_load(1, 0, lc);
    do_run(4, 2, 1'b0, rc);
  endtask

  task automatic test_random();
    int lc, rc, cnt;
    bit ab;
    for (int i = 0; i < 8; i++) begin
      cnt = $urandom_range(0, 5);
      ab = (cnt > 0) && ($urandom_range(0, 3) == 0);
      do_start(cnt);
      do_load(1, 0, lc);
      do_run(cnt, 2, ab, rc);
      tick();
    end
  endtask

  task automatic test_async_reset();
    int lc;
    do_start(3);
    do_load(0, 0, lc);
    repeat (5) tick();
    n_cmp++;
    if ({exec_en_o, busy_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL async_pre got e=%b b=%b exp 11",
               exec_en_o, busy_o);
    end
    #3;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, exec_en_o, loaded_o, tile_wr_valid_o,
         iter_o, exec_ctx_o, cfg_rd_ctx_o} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got b=%b e=%b l=%b it=%0d ctx=%0d exp 0",
               busy_o, exec_en_o, loaded_o, iter_o, exec_ctx_o);
    end
    #10;
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    for (int c = 0; c < K; c++)
      for (int t = 0; t < D; t++)
        mem[c][t] = CW'({$urandom, $urandom});
    test_reset();
    test_basic();
    test_slow_tile();
    test_zero_iter();
    test_stall();
    test_abort_load();
    test_abort_priority();
    test_start_ignored();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cgra_cfg_exec_sequencer.md
Name: cgra_cfg_exec_sequencer

Overview:
Top-level controller for the CGRA tile array. On a start command it broadcasts KernelSize configuration contexts from the CSR-side config store into every tile's config memory, using per-tile valid/ready handshakes. It then steps the array through the modulo schedule, cycling the context index for a programmed number of iterations. It sits between the CSR register block (start, status, iteration count) and the tile array (config write port, context select).

Parameters:
CGRADim, 16, number of tiles
KernelSize, 4, contexts per tile; must be >= 2
CfgWidth, 49, packed tile config word width
IterWidth, 16, iteration counter width
CtxW, max(1,$clog2(KernelSize)), derived context index width; not overridable

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start pulse from CSR block
iter_count_i  in  IterWidth  iterations to run; sampled when start is accepted
abort_i  in  1  synchronous abort
stall_i  in  1  freezes the run-phase context/iteration counters
cfg_rd_ctx_o  out  CtxW  context index presented to the config store
cfg_rd_data_i  in  CGRADim x CfgWidth  config words for cfg_rd_ctx_o, combinational, same cycle
tile_wr_addr_o  out  CtxW  broadcast config write address (equals cfg_rd_ctx_o)
tile_wr_data_o  out  CGRADim x CfgWidth  passthrough of cfg_rd_data_i
tile_wr_valid_o  out  CGRADim  per-tile write valid
tile_ready_i  in  CGRADim  per-tile write ready
exec_en_o  out  1  array executes this cycle
exec_ctx_o  out  CtxW  active context during run
busy_o  out  1  state != IDLE
loaded_o  out  1  all contexts delivered since the last start
done_o  out  1  one-cycle completion pulse
iter_o  out  IterWidth  completed iterations

Behaviour:
- Reset values: all outputs 0; state IDLE; accepted mask 0; counters 0. Reset mid-operation returns to IDLE immediately and deasserts every valid.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start_i=1 → LOAD next cycle.
  - Latch iter_count_i; clear ctx, iteration counter and loaded_o.
  - start_i is ignored in every other state.
- LOAD:
  - tile_wr_valid_o[t] = ~accepted[t]. accepted[t] sets on valid&ready.
  - Write address and data stay stable while any valid is high.
  - When (accepted | (valid&ready)) is all ones, clear the mask and increment ctx in that same cycle. Next context is offered the following cycle, giving 1 cycle per context with all tiles ready.
  - After ctx KernelSize-1 completes: loaded_o←1, ctx←0, then RUN (or DONE directly if the latched count is 0).
  - A tile whose ready stays low stalls the load indefinitely; there is no timeout.
- RUN:
  - exec_en_o = ~stall_i; exec_ctx_o = ctx.
  - Each non-stalled cycle, ctx increments and wraps KernelSize-1 → 0. On wrap, iter_o increments.
  - When ctx==KernelSize-1, iter_o==count-1 and not stalled, go to DONE.
  - stall_i holds ctx and iter_o.
- DONE: done_o=1 for exactly one cycle; exec_en_o=0; then IDLE. loaded_o and iter_o hold until the next start.
- abort_i (any non-IDLE state) → IDLE next cycle:
  - All valids and exec_en_o drop; done_o is not pulsed; loaded_o is cleared.
  - abort_i has priority over every other transition, including completion in the same cycle.
- Widths: a count of 2^IterWidth-1 is legal; iter_o does not wrap before done.

Decomposition:
- Package cgra_ctrl_pkg holds:
  - state enum seq_state_e {IDLE, LOAD, RUN, DONE};
  - localparam function ctx_width(KernelSize);
  - typedef cfg_word_t = logic [CfgWidth-1:0]. The CSR block and tiles import the same type.
- One sub-module: cgra_tile_accept_tracker. Parameter CGRADim. Inputs valid, ready, clr. Outputs accepted mask and all_done. Owns the per-tile accepted register.

Test Plan (CGRADim=4, KernelSize=4, IterWidth=16):
- All ready, iter_count=3, start at cycle 0:
  - LOAD in cycles 1-4 with addr 0,1,2,3 and valid=4'hF;
  - RUN in cycles 5-16 with exec_ctx 0,1,2,3 repeating;
  - done_o high in cycle 17 only; iter_o=3; busy_o low in cycle 18.
- Tile 2 ready low for 3 cycles at ctx 1:
  - valid goes 4'hF, then 4'h4 for 3 cycles;
  - ctx 2 is issued only after tile 2 accepts; total load takes 7 cycles.
- iter_count=0: LOAD completes, loaded_o=1, straight to DONE; exec_en_o never asserts.
- stall_i high for 5 cycles mid-RUN: exec_ctx and iter_o are frozen; done is delayed by exactly 5 cycles.
- abort_i during LOAD at ctx 2: valids drop next cycle; state IDLE; done_o never pulses; loaded_o=0. A new start reloads from ctx 0.
- start_i pulsed during RUN is ignored (iter_o is unaffected). Async reset asserted mid-RUN clears all outputs without waiting for a clock edge.
